// File: rtl/acquisition_sequencer.sv
// acquisition_sequencer: repeated arm -> settle -> capture -> readout -> holdoff cycles.
// The auto-trigger timeout is built only when ACQ_SEQ_AUTO_TRIGGER_EN is defined.
module acquisition_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt,
    input  logic        single,
    input  logic        auto_mode,
    input  logic [15:0] auto_timeout,
    input  logic [15:0] holdoff,
    input  logic        bc_buffer_full,
    input  logic        bc_triggered,
    output logic        bc_start,
    output logic        bc_stop,
    output logic        rd_start,
    input  logic        rd_done,
    output logic        busy,
    output logic        forced,
    output logic [15:0] acq_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        READOUT = 3'd4,
        HOLDOFF = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        halt_pend_q, halt_pend_d;
    logic        bc_start_q, bc_start_d;
    logic        bc_stop_q, bc_stop_d;
    logic        rd_start_q, rd_start_d;
    logic        busy_q, busy_d;
    logic        forced_q, forced_d;
    logic [15:0] acq_count_q, acq_count_d;
    logic        capture_s;

`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_cond_s;
    assign to_cond_s = auto_mode & bc_buffer_full & ~bc_triggered;
`else
    logic        unused_auto_s;
    assign unused_auto_s = auto_mode ^ (^auto_timeout);
`endif

    assign capture_s = bc_buffer_full & bc_triggered;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        forced_d    = forced_q;
        acq_count_d = acq_count_q;
        bc_start_d  = 1'b0;
        bc_stop_d   = 1'b0;
        rd_start_d  = 1'b0;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
        to_cnt_d    = 16'd0;
`endif
        case (state_q)
            IDLE: begin
                halt_pend_d = 1'b0;
                if (run && !halt) begin
                    state_d    = ARM;
                    bc_start_d = 1'b1;
                    forced_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                cnt_d = 16'd0;
                if (halt) begin
                    state_d   = IDLE;
                    bc_stop_d = 1'b1;
                end else begin
                    state_d = SETTLE;
                end
            end
            // Buffer flags are stale for two cycles after start, so they are not looked at here.
            SETTLE: begin
                if (halt) begin
                    state_d   = IDLE;
                    bc_stop_d = 1'b1;
                end else if (cnt_q == 16'd1) begin
                    state_d = CAPTURE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                if (halt) begin
                    state_d   = IDLE;
                    bc_stop_d = 1'b1;
                end else if (capture_s) begin
                    state_d    = READOUT;
                    rd_start_d = 1'b1;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
                end else if (to_cond_s) begin
                    if (to_cnt_q == auto_timeout) begin
                        state_d    = READOUT;
                        rd_start_d = 1'b1;
                        bc_stop_d  = 1'b1;
                        forced_d   = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    state_d = CAPTURE;
                end
            end
            // A running readout is never aborted; a halt only skips the holdoff afterwards.
            READOUT: begin
                if (rd_done) begin
                    acq_count_d = acq_count_q + 16'd1;
                    cnt_d       = 16'd0;
                    if (halt || halt_pend_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                    end
                end else if (halt) begin
                    halt_pend_d = 1'b1;
                end else begin
                    state_d = READOUT;
                end
            end
            HOLDOFF: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (cnt_q == holdoff) begin
                    if (single || halt_pend_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = ARM;
                        bc_start_d = 1'b1;
                        forced_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            halt_pend_q <= 1'b0;
            bc_start_q  <= 1'b0;
            bc_stop_q   <= 1'b0;
            rd_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            forced_q    <= 1'b0;
            acq_count_q <= 16'd0;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
            to_cnt_q    <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            bc_start_q  <= bc_start_d;
            bc_stop_q   <= bc_stop_d;
            rd_start_q  <= rd_start_d;
            busy_q      <= busy_d;
            forced_q    <= forced_d;
            acq_count_q <= acq_count_d;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign bc_start  = bc_start_q;
    assign bc_stop   = bc_stop_q;
    assign rd_start  = rd_start_q;
    assign busy      = busy_q;
    assign forced    = forced_q;
    assign acq_count = acq_count_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Bench for acquisition_sequencer: scenario tasks plus randomized acquisition runs whose
// pulse cycles are predicted arithmetically from the sequencing rules.
module tb_acquisition_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, halt, single, auto_mode, bc_buffer_full, bc_triggered, rd_done;
    logic [15:0] auto_timeout, holdoff;
    logic        bc_start, bc_stop, rd_start, busy, forced;
    logic [15:0] acq_count;
    logic [15:0] exp_count;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          q_start[$];
    int          q_stop[$];
    int          q_rd[$];

    acquisition_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .single(single),
        .auto_mode(auto_mode), .auto_timeout(auto_timeout), .holdoff(holdoff),
        .bc_buffer_full(bc_buffer_full), .bc_triggered(bc_triggered),
        .bc_start(bc_start), .bc_stop(bc_stop), .rd_start(rd_start), .rd_done(rd_done),
        .busy(busy), .forced(forced), .acq_count(acq_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of every output pulse.
    always @(negedge clk) begin
        if (bc_start === 1'b1) q_start.push_back(cyc);
        if (bc_stop === 1'b1) q_stop.push_back(cyc);
        if (rd_start === 1'b1) q_rd.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic clear_q();
        q_start.delete();
        q_stop.delete();
        q_rd.delete();
    endtask

    task automatic idle_inputs();
        run = 1'b0; halt = 1'b0; single = 1'b0; auto_mode = 1'b0;
        auto_timeout = 16'd0; holdoff = 16'd0;
        bc_buffer_full = 1'b0; bc_triggered = 1'b0; rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) step();
        rst = 1'b0;
        exp_count = 16'd0;
        step();
        clear_q();
        checks++; if (bc_start !== 1'b0) begin errors++; $display("FAIL reset_bc_start: got %b want 0", bc_start); end
        checks++; if (bc_stop !== 1'b0) begin errors++; $display("FAIL reset_bc_stop: got %b want 0", bc_stop); end
        checks++; if (rd_start !== 1'b0) begin errors++; $display("FAIL reset_rd_start: got %b want 0", rd_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (forced !== 1'b0) begin errors++; $display("FAIL reset_forced: got %b want 0", forced); end
        checks++; if (acq_count !== 16'd0) begin errors++; $display("FAIL reset_acq_count: got %0h want 0", acq_count); end
        // halt, stray rd_done and run+halt together while idle must all do nothing
        halt = 1'b1; step(); halt = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        run = 1'b1; halt = 1'b1; step(); run = 1'b0; halt = 1'b0;
        repeat (3) step();
        checks++; if (q_stop.size() !== 0) begin errors++; $display("FAIL idle_halt_stop: got %0d pulses want 0", q_stop.size()); end
        checks++; if (q_start.size() !== 0) begin errors++; $display("FAIL idle_run_halt: got %0d starts want 0", q_start.size()); end
        checks++; if (acq_count !== exp_count) begin errors++; $display("FAIL idle_rd_done: got %0h want %0h", acq_count, exp_count); end
    endtask

    task automatic test_single_trigger();
        int n, r;
        clear_q();
        single = 1'b1; holdoff = 16'd0;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        checks++; if (bc_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_arm: got start=%b busy=%b want 1 1", bc_start, busy); end
        wait_to(n + 4);
        bc_buffer_full = 1'b1; bc_triggered = 1'b1;
        repeat (3) step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        wait_to(n + 8);
        r = cyc; rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        checks++; if (acq_count !== exp_count || busy !== 1'b1) begin errors++; $display("FAIL single_count: got %0h busy=%b want %0h busy=1", acq_count, busy, exp_count); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b at rd_done+2 want 0", busy); end
        step();
        checks++; if (q_start.size() !== 1 || q_start[0] !== n + 1) begin errors++; $display("FAIL single_start: got %0d pulses first@%0d want 1 @%0d", q_start.size(), q_start[0], n + 1); end
        checks++; if (q_rd.size() !== 1 || q_rd[0] !== n + 5) begin errors++; $display("FAIL single_rd_start: got %0d pulses first@%0d want 1 @%0d", q_rd.size(), q_rd[0], n + 5); end
        checks++; if (q_stop.size() !== 0) begin errors++; $display("FAIL single_stop: got %0d want 0", q_stop.size()); end
        checks++; if (r !== n + 8) begin errors++; $display("FAIL single_sched: got %0d want %0d", r, n + 8); end
    endtask

    task automatic test_continuous_holdoff();
        int n, r1, r2;
        clear_q();
        single = 1'b0; holdoff = 16'd5;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4);
        bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        wait_to(n + 6);
        r1 = cyc; rd_done = 1'b1; step(); rd_done = 1'b0;
        wait_to(r1 + 10);
        bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        single = 1'b1;
        r2 = cyc; rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd2;
        wait_to(r2 + 6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_holdoff_busy: got %b at last holdoff cycle want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_exit_idle: got busy=%b want 0", busy); end
        checks++; if (q_start.size() !== 2 || q_start[1] !== r1 + 7) begin errors++; $display("FAIL cont_rearm: got %0d starts second@%0d want 2 @%0d", q_start.size(), q_start[1], r1 + 7); end
        checks++; if (q_rd.size() !== 2 || q_rd[1] !== r1 + 11) begin errors++; $display("FAIL cont_rd_start: got %0d second@%0d want 2 @%0d", q_rd.size(), q_rd[1], r1 + 11); end
        checks++; if (acq_count !== exp_count) begin errors++; $display("FAIL cont_count: got %0h want %0h", acq_count, exp_count); end
    endtask

    task automatic test_stale_flags();
        int n;
        clear_q();
        single = 1'b1; holdoff = 16'd0;
        n = cyc; run = 1'b1; bc_buffer_full = 1'b1; bc_triggered = 1'b1; step(); run = 1'b0;
        wait_to(n + 5);
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        checks++; if (rd_start !== 1'b1) begin errors++; $display("FAIL stale_rd_start: got %b at capture+1 want 1", rd_start); end
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        repeat (2) step();
        checks++; if (q_rd.size() !== 1 || q_rd[0] !== n + 5) begin errors++; $display("FAIL stale_early: got %0d first@%0d want 1 @%0d", q_rd.size(), q_rd[0], n + 5); end
        repeat (3) begin rd_done = 1'b1; step(); rd_done = 1'b0; step(); end
        checks++; if (acq_count !== exp_count || busy !== 1'b0) begin errors++; $display("FAIL idle_rd_done_count: got %0h busy=%b want %0h busy=0", acq_count, busy, exp_count); end
    endtask

    task automatic test_halt();
        int n;
        // halt during CAPTURE
        clear_q(); single = 1'b0; holdoff = 16'd2;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4); bc_buffer_full = 1'b1;
        wait_to(n + 6); halt = 1'b1; step(); halt = 1'b0; bc_buffer_full = 1'b0;
        checks++; if (bc_stop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_capture: got stop=%b busy=%b want 1 0", bc_stop, busy); end
        step();
        checks++; if (bc_stop !== 1'b0 || q_rd.size() !== 0) begin errors++; $display("FAIL halt_capture_pulse: got stop=%b rd=%0d want 0 0", bc_stop, q_rd.size()); end
        // halt during ARM
        clear_q();
        n = cyc; run = 1'b1; step(); run = 1'b0;
        halt = 1'b1; step(); halt = 1'b0;
        checks++; if (bc_stop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL halt_arm: got stop=%b busy=%b want 1 0", bc_stop, busy); end
        // halt during READOUT: readout completes, no holdoff, no re-arm
        repeat (2) step(); clear_q();
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4); bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        step(); halt = 1'b1; step(); halt = 1'b0;
        wait_to(n + 9);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_readout_wait: got busy=%b want 1", busy); end
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        checks++; if (busy !== 1'b0 || acq_count !== exp_count) begin errors++; $display("FAIL halt_readout_done: got busy=%b count=%0h want 0 %0h", busy, acq_count, exp_count); end
        repeat (6) step();
        checks++; if (q_start.size() !== 1 || q_stop.size() !== 0) begin errors++; $display("FAIL halt_readout_rearm: got starts=%0d stops=%0d want 1 0", q_start.size(), q_stop.size()); end
        // halt during HOLDOFF
        clear_q(); holdoff = 16'd5;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4); bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        wait_to(n + 8); halt = 1'b1; step(); halt = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_holdoff: got busy=%b want 0", busy); end
        repeat (8) step();
        checks++; if (q_start.size() !== 1 || q_stop.size() !== 0 || acq_count !== exp_count) begin errors++; $display("FAIL halt_holdoff_after: got starts=%0d stops=%0d count=%0h want 1 0 %0h", q_start.size(), q_stop.size(), acq_count, exp_count); end
    endtask

    task automatic test_no_auto();
        int n;
        clear_q(); single = 1'b1; holdoff = 16'd0; auto_timeout = 16'd0;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
        auto_mode = 1'b0;
`else
        auto_mode = 1'b1;
`endif
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4); bc_buffer_full = 1'b1;
        wait_to(n + 24);
        checks++; if (q_rd.size() !== 0 || q_stop.size() !== 0 || busy !== 1'b1 || forced !== 1'b0) begin errors++; $display("FAIL no_auto_wait: got rd=%0d stop=%0d busy=%b forced=%b want 0 0 1 0", q_rd.size(), q_stop.size(), busy, forced); end
        halt = 1'b1; step(); halt = 1'b0; bc_buffer_full = 1'b0; auto_mode = 1'b0;
        checks++; if (bc_stop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL no_auto_halt: got stop=%b busy=%b want 1 0", bc_stop, busy); end
        step();
    endtask

`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
    task automatic test_auto_timeout();
        int n, c0, f, to, gap;
        for (int k = 0; k < 3; k++) begin
            to  = (k == 0) ? 10 : ((k == 1) ? 0 : 3);
            gap = (k == 2) ? 2 : -1;
            clear_q(); auto_mode = 1'b1; auto_timeout = 16'(to); single = 1'b1; holdoff = 16'd0;
            n = cyc; run = 1'b1; step(); run = 1'b0;
            c0 = n + 4;
            f = (gap < 0) ? c0 + to : c0 + gap + 1 + to;
            wait_to(c0);
            while (cyc < f + 1) begin
                bc_buffer_full = (gap >= 0 && cyc == c0 + gap) ? 1'b0 : 1'b1;
                step();
            end
            bc_buffer_full = 1'b0;
            checks++; if (bc_stop !== 1'b1 || rd_start !== 1'b1 || forced !== 1'b1) begin errors++; $display("FAIL auto_force_%0d: got stop=%b rd=%b forced=%b want 1 1 1", k, bc_stop, rd_start, forced); end
            rd_done = 1'b1; step(); rd_done = 1'b0;
            exp_count = exp_count + 16'd1;
            repeat (2) step();
            checks++; if (q_stop.size() !== 1 || q_stop[0] !== f + 1 || q_rd.size() !== 1 || q_rd[0] !== f + 1) begin errors++; $display("FAIL auto_timing_%0d: got stop@%0d rd@%0d want @%0d", k, q_stop[0], q_rd[0], f + 1); end
            checks++; if (forced !== 1'b1 || busy !== 1'b0 || acq_count !== exp_count) begin errors++; $display("FAIL auto_after_%0d: got forced=%b busy=%b count=%0h want 1 0 %0h", k, forced, busy, acq_count, exp_count); end
        end
        // trigger arriving on the timeout cycle wins
        clear_q(); auto_timeout = 16'd10;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        c0 = n + 4;
        wait_to(c0); bc_buffer_full = 1'b1;
        wait_to(c0 + 10); bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        checks++; if (rd_start !== 1'b1 || bc_stop !== 1'b0 || forced !== 1'b0) begin errors++; $display("FAIL auto_tie: got rd=%b stop=%b forced=%b want 1 0 0", rd_start, bc_stop, forced); end
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        repeat (2) step();
        checks++; if (q_stop.size() !== 0 || forced !== 1'b0) begin errors++; $display("FAIL auto_tie_after: got stops=%0d forced=%b want 0 0", q_stop.size(), forced); end
        auto_mode = 1'b0;
    endtask
`endif

    task automatic test_wrap();
        force dut.acq_count_q = 16'hFFFF;
        step();
        release dut.acq_count_q;
        step();
        exp_count = 16'hFFFF;
        checks++; if (acq_count !== exp_count) begin errors++; $display("FAIL wrap_preload: got %0h want %0h", acq_count, exp_count); end
        single = 1'b1; holdoff = 16'd0;
        run = 1'b1; step(); run = 1'b0;
        repeat (3) step();
        bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        step(); step();
        checks++; if (acq_count !== 16'h0000 || acq_count !== exp_count) begin errors++; $display("FAIL wrap: got %0h want 0000", acq_count); end
    endtask

    task automatic test_random();
        int na, hd, n, a, t, r, x, last;
        int a_t[$], t_t[$], r_t[$], x_t[$];
        for (int it = 0; it < 8; it++) begin
            na = $urandom_range(3, 1); hd = $urandom_range(6, 0);
            holdoff = 16'(hd); auto_mode = 1'b0;
            a_t.delete(); t_t.delete(); r_t.delete(); x_t.delete();
            step(); clear_q();
            n = cyc; a = n + 1;
            for (int i = 0; i < na; i++) begin
                t = a + 3 + $urandom_range(4, 0);
                r = t + 1 + $urandom_range(3, 0);
                x = r + 1 + hd;
                a_t.push_back(a); t_t.push_back(t); r_t.push_back(r); x_t.push_back(x);
                a = x + 1;
            end
            last = x_t[na - 1];
            for (int c = n; c <= last + 2; c++) begin
                run = (c == n) || (c >= a_t[0] && c <= last && $urandom_range(5, 0) == 0);
                bc_buffer_full = 1'($urandom_range(1, 0));
                bc_triggered = 1'($urandom_range(1, 0));
                single = 1'($urandom_range(1, 0));
                rd_done = (c < a_t[0] || c > last) ? 1'($urandom_range(1, 0)) : 1'b0;
                for (int i = 0; i < na; i++) begin
                    if (c >= a_t[i] + 3 && c < t_t[i] && bc_triggered) bc_buffer_full = 1'b0;
                    if (c >= a_t[i] && c < t_t[i]) rd_done = ($urandom_range(3, 0) == 0);
                    if (c == t_t[i]) begin bc_buffer_full = 1'b1; bc_triggered = 1'b1; end
                    if (c == r_t[i]) rd_done = 1'b1;
                    if (c > r_t[i] && c <= x_t[i]) rd_done = ($urandom_range(2, 0) == 0);
                    if (c == x_t[i]) single = (i == na - 1);
                end
                step();
            end
            run = 1'b0; rd_done = 1'b0; bc_buffer_full = 1'b0; bc_triggered = 1'b0;
            exp_count = exp_count + 16'(na);
            checks++; if (q_start.size() !== na || q_rd.size() !== na || q_stop.size() !== 0) begin errors++; $display("FAIL rand_%0d_pulses: got start=%0d rd=%0d stop=%0d want %0d %0d 0", it, q_start.size(), q_rd.size(), q_stop.size(), na, na); end
            for (int i = 0; i < na && i < q_start.size() && i < q_rd.size(); i++) begin
                checks++; if (q_start[i] !== a_t[i] || q_rd[i] !== t_t[i] + 1) begin errors++; $display("FAIL rand_%0d_acq_%0d: got start@%0d rd@%0d want @%0d @%0d", it, i, q_start[i], q_rd[i], a_t[i], t_t[i] + 1); end
            end
            checks++; if (acq_count !== exp_count || busy !== 1'b0) begin errors++; $display("FAIL rand_%0d_end: got count=%0h busy=%b want %0h 0", it, acq_count, busy, exp_count); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        single = 1'b0; holdoff = 16'd0; auto_mode = 1'b0;
        n = cyc; run = 1'b1; step(); run = 1'b0;
        wait_to(n + 4); bc_buffer_full = 1'b1; bc_triggered = 1'b1; step();
        bc_buffer_full = 1'b0; bc_triggered = 1'b0;
        rd_done = 1'b1; step(); rd_done = 1'b0;
        exp_count = exp_count + 16'd1;
        wait_to(n + 11);
        checks++; if (busy !== 1'b1 || acq_count !== exp_count) begin errors++; $display("FAIL pre_reset: got busy=%b count=%0h want 1 %0h", busy, acq_count, exp_count); end
        clear_q();
        #2 rst = 1'b1;
        #1;
        checks++; if ({bc_start, bc_stop, rd_start, busy, forced} !== 5'b00000 || acq_count !== 16'd0) begin errors++; $display("FAIL async_reset: got flags=%b count=%0h want 00000 0", {bc_start, bc_stop, rd_start, busy, forced}, acq_count); end
        step(); rst = 1'b0; exp_count = 16'd0;
        repeat (4) step();
        checks++; if (q_stop.size() !== 0 || q_start.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset: got stops=%0d starts=%0d busy=%b want 0 0 0", q_stop.size(), q_start.size(), busy); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_trigger();
        test_continuous_holdoff();
        test_stale_flags();
        test_halt();
        test_no_auto();
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
        test_auto_timeout();
`endif
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acquisition_sequencer.md
# acquisition_sequencer

Sequences repeated capture cycles of the sample-buffer controller and the RAM readout path. It arms the buffer controller and waits for a completed triggered capture, or forces one on timeout in auto mode. It then launches the RAM readout, applies a holdoff, and re-arms unless single-shot is selected. It sits between the host command decoder and the buffer controller / RAM readout engine.

## Interface
- no parameters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  one-cycle pulse: start acquisitions (ignored unless IDLE)
- halt  in  1  one-cycle pulse: abort acquisitions; priority over run
- single  in  1  level: 1 = stop after one acquisition
- auto_mode  in  1  level: 1 = force readout on trigger timeout
- auto_timeout  in  16  cycles to wait with buffer full and no trigger
- holdoff  in  16  extra cycles between readout done and re-arm
- bc_buffer_full  in  1  buffer controller buffer-full flag
- bc_triggered  in  1  buffer controller triggered flag
- bc_start  out  1  one-cycle pulse to buffer controller start
- bc_stop  out  1  one-cycle pulse to buffer controller stop
- rd_start  out  1  one-cycle pulse: launch RAM readout
- rd_done  in  1  one-cycle pulse: readout finished
- busy  out  1  high whenever state != IDLE
- forced  out  1  last acquisition was forced by timeout
- acq_count  out  16  completed readouts, wraps 0xFFFF -> 0

## Operation
- States: IDLE, ARM, SETTLE, CAPTURE, READOUT, HOLDOFF. All outputs registered.
- Reset values: state IDLE, bc_start/bc_stop/rd_start/busy/forced = 0, acq_count = 0, counters = 0.
- IDLE: run -> ARM.
- ARM (1 cycle): bc_start = 1, forced <= 0 -> SETTLE.
- SETTLE (2 cycles): bc flags ignored; they are stale for up to two cycles after start -> CAPTURE.
- CAPTURE: bc_buffer_full && bc_triggered -> READOUT.
- Auto timeout in CAPTURE: auto_mode && bc_buffer_full && !bc_triggered increments timeout counter; any cycle without that condition clears it.
- Counter == auto_timeout with condition true -> bc_stop = 1, forced <= 1 -> READOUT. auto_timeout = 0 forces on the first qualifying cycle.
- Simultaneous timeout and triggered: triggered wins; no bc_stop, forced stays 0.
- READOUT: rd_start = 1 on entry cycle only. rd_done -> acq_count + 1 -> HOLDOFF.
- HOLDOFF: counter from 0; exit when counter == holdoff, giving holdoff+1 cycles. Exit goes to IDLE if single == 1 or a halt is pending, else ARM. single is sampled only at exit.
- halt in ARM/SETTLE/CAPTURE: bc_stop = 1 next cycle -> IDLE.
- halt in READOUT: readout is never aborted; set halt_pending, finish through rd_done (acq_count still increments), skip HOLDOFF -> IDLE.
- halt in HOLDOFF -> IDLE. halt in IDLE: no effect, no bc_stop.
- rd_done outside READOUT: ignored. run while busy: ignored.

## Timing
- run at cycle N -> bc_start high in N+1, SETTLE N+2..N+3, CAPTURE from N+4.
- Capture condition seen at M -> rd_start high in M+1.
- Forced timeout at M -> bc_stop and rd_start both high in M+1.
- rd_done at R -> acq_count updated at R+1, HOLDOFF R+1..R+1+holdoff, bc_start re-pulsed at R+2+holdoff (continuous).
- halt at H in capture states -> bc_stop high H+1, busy low H+1.
- Reset mid-operation: all outputs return to reset values immediately; no bc_stop is issued.

## Configuration
- Macro ACQ_SEQ_AUTO_TRIGGER_EN.
- Defined: auto_mode and auto_timeout behave as above; the timeout counter is present.
- Undefined: auto_mode and auto_timeout are ignored and the counter is not built. CAPTURE waits indefinitely; forced is constant 0; bc_stop is driven only by halt.

## Test plan
- single=1, holdoff=0, run; hold full&&triggered high 3 cycles after CAPTURE entry -> one bc_start, rd_start 1 cycle later; rd_done -> acq_count=1, busy low 2 cycles after rd_done.
- single=0, holdoff=5, two triggered captures -> bc_start re-pulsed exactly 7 cycles after first rd_done, acq_count=2.
- (macro on) auto_mode=1, auto_timeout=10, full=1, triggered=0 -> bc_stop+rd_start 11 cycles after first full cycle, forced=1; triggered at the same cycle as timeout -> forced=0, no bc_stop.
- halt in CAPTURE -> bc_stop next cycle, IDLE; halt in READOUT -> rd_done still awaited, acq_count increments, IDLE with no re-arm.
- bc flags held 1 during ARM/SETTLE -> no rd_start before CAPTURE; rd_done in IDLE -> no count change.
- acq_count=0xFFFF, one more readout -> 0x0000; async rst mid-CAPTURE -> all outputs 0 immediately.
